// File: rtl/sched_pkg.sv
// sched_pkg: shared task-id types, dispatcher states and one-hot helper
package sched_pkg;
  localparam int NTASK = 16;
  localparam int TID_W = $clog2(NTASK);
  typedef logic [TID_W-1:0] tid_t;
  typedef enum logic [1:0] {IDLE, LAUNCH, RUN, SETTLE} disp_state_t;
  function automatic logic [NTASK-1:0] tid_onehot(input tid_t tid);
    return NTASK'(1) << tid;
  endfunction
endpackage

// File: rtl/slice_timer.sv
// slice_timer: time-slice down-counter that reloads instead of underflowing
module slice_timer #(
  parameter int SLICE_CYCLES = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic dec,
  output logic expired
);
  localparam int CW = $clog2(SLICE_CYCLES);
  localparam logic [CW-1:0] TOP = CW'(SLICE_CYCLES - 1);
  logic [CW-1:0] cnt;
  always_ff @(posedge clk) begin
    if (rst) cnt <= '0;
    else if (load || (dec && cnt == '0)) cnt <= TOP;
    else if (dec) cnt <= cnt - 1'b1;
  end
  assign expired = cnt == '0;
endmodule

// File: rtl/task_dispatcher.sv
// task_dispatcher: pops the ready-queue head, hands it to the CPU and time-slices it
module task_dispatcher
  import sched_pkg::*;
#(
  parameter int SLICE_CYCLES = 1000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [TID_W-1:0] qhead_tid,
  input  logic             empty_flag,
  output logic [NTASK-1:0] dequeue,
  output logic [NTASK-1:0] enqueue,
  output logic [NTASK-1:0] que_blk,
  output logic [NTASK-1:0] remove,
  output logic             switch_req,
  output logic [TID_W-1:0] switch_tid,
  input  logic             switch_ack,
  input  logic             cpu_exit,
  input  logic             cpu_block,
  input  logic             cpu_yield,
  output logic             running_valid,
  output logic [TID_W-1:0] running_tid
);
  disp_state_t state;
  logic expired;
  slice_timer #(.SLICE_CYCLES(SLICE_CYCLES)) u_timer (
    .clk(clk),
    .rst(rst),
    .load(state == LAUNCH && switch_ack),
    .dec(state == RUN),
    .expired(expired)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      dequeue <= '0;
      enqueue <= '0;
      que_blk <= '0;
      remove <= '0;
      switch_req <= 1'b0;
      switch_tid <= '0;
      running_valid <= 1'b0;
      running_tid <= '0;
    end else begin
      dequeue <= '0;
      enqueue <= '0;
      que_blk <= '0;
      remove <= '0;
      case (state)
        IDLE: if (!empty_flag) begin
          switch_tid <= qhead_tid;
          dequeue <= tid_onehot(qhead_tid);
          switch_req <= 1'b1;
          state <= LAUNCH;
        end
        LAUNCH: if (switch_ack) begin
          switch_req <= 1'b0;
          running_valid <= 1'b1;
          running_tid <= switch_tid;
          state <= RUN;
        end
        // expiry on an empty queue falls through: the timer reloads and the task keeps running
        RUN: if (cpu_exit || cpu_block || cpu_yield || (expired && !empty_flag)) begin
          running_valid <= 1'b0;
          state <= SETTLE;
          if (cpu_exit) remove <= tid_onehot(running_tid);
          else if (cpu_block) que_blk <= tid_onehot(running_tid);
          else enqueue <= tid_onehot(running_tid);
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_task_dispatcher.sv
// tb_task_dispatcher: directed checks of dispatch, slicing, priority and reset
module tb_task_dispatcher;
  import sched_pkg::*;
  logic clk = 1'b0;
  logic rst, empty_flag, switch_ack, cpu_exit, cpu_block, cpu_yield;
  logic [TID_W-1:0] qhead_tid;
  logic [NTASK-1:0] dequeue, enqueue, que_blk, remove;
  logic switch_req, running_valid;
  logic [TID_W-1:0] switch_tid, running_tid;
  int errors = 0;
  int checks = 0;

  task_dispatcher #(.SLICE_CYCLES(8)) dut (
    .clk(clk), .rst(rst), .qhead_tid(qhead_tid), .empty_flag(empty_flag),
    .dequeue(dequeue), .enqueue(enqueue), .que_blk(que_blk), .remove(remove),
    .switch_req(switch_req), .switch_tid(switch_tid), .switch_ack(switch_ack),
    .cpu_exit(cpu_exit), .cpu_block(cpu_block), .cpu_yield(cpu_yield),
    .running_valid(running_valid), .running_tid(running_tid)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Queue pops instantly on dispatch; ack is given on the first LAUNCH cycle.
  task automatic dispatch(input logic [TID_W-1:0] tid);
    int n;
    n = 0;
    qhead_tid = tid;
    empty_flag = 1'b0;
    do begin
      cyc();
      n++;
    end while (!switch_req && n < 6);
    checks++;
    if (switch_req !== 1'b1 || switch_tid !== tid) begin
      errors++;
      $display("FAIL dispatch_wait tid %0d: switch_req=%b switch_tid=%0d required 1/%0d", tid, switch_req, switch_tid, tid);
    end
    empty_flag = 1'b1;
    switch_ack = 1'b1;
    cyc();
    switch_ack = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    empty_flag = 1'b1;
    qhead_tid = '0;
    switch_ack = 1'b0;
    cpu_exit = 1'b0;
    cpu_block = 1'b0;
    cpu_yield = 1'b0;
    repeat (3) cyc();
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      cpu_exit = (i >= 10);
      switch_ack = (i >= 10);
      cyc();
      checks++;
      if ({dequeue, enqueue, que_blk, remove, switch_req, switch_tid, running_valid, running_tid} !== '0) begin
        errors++;
        $display("FAIL reset_idle cycle %0d: outputs=%h required 0", i,
                 {dequeue, enqueue, que_blk, remove, switch_req, switch_tid, running_valid, running_tid});
      end
    end
    cpu_exit = 1'b0;
    switch_ack = 1'b0;
  endtask

  task automatic test_dispatch();
    qhead_tid = 4'd5;
    empty_flag = 1'b0;
    cyc();
    checks++;
    if (dequeue !== 16'h0020 || switch_req !== 1'b1 || switch_tid !== 4'd5) begin
      errors++;
      $display("FAIL dispatch_start: dequeue=%h req=%b tid=%0d required 0020/1/5", dequeue, switch_req, switch_tid);
    end
    empty_flag = 1'b1;
    qhead_tid = '0;
    cyc();
    checks++;
    if (dequeue !== 16'h0000 || switch_req !== 1'b1 || switch_tid !== 4'd5) begin
      errors++;
      $display("FAIL dispatch_hold1: dequeue=%h req=%b tid=%0d required 0000/1/5", dequeue, switch_req, switch_tid);
    end
    cyc();
    checks++;
    if (switch_req !== 1'b1 || switch_tid !== 4'd5 || running_valid !== 1'b0) begin
      errors++;
      $display("FAIL dispatch_hold2: req=%b tid=%0d valid=%b required 1/5/0", switch_req, switch_tid, running_valid);
    end
    switch_ack = 1'b1;
    cyc();
    switch_ack = 1'b0;
    checks++;
    if (switch_req !== 1'b0 || running_valid !== 1'b1 || running_tid !== 4'd5) begin
      errors++;
      $display("FAIL dispatch_ack: req=%b valid=%b running_tid=%0d required 0/1/5", switch_req, running_valid, running_tid);
    end
  endtask

  task automatic test_expiry();
    qhead_tid = 4'd9;
    empty_flag = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      cyc();
      checks++;
      if (c < 8 && (enqueue !== '0 || running_valid !== 1'b1)) begin
        errors++;
        $display("FAIL expiry_early cycle %0d: enqueue=%h valid=%b required 0000/1", c, enqueue, running_valid);
      end else if (c == 8 && (enqueue !== 16'h0020 || running_valid !== 1'b0)) begin
        errors++;
        $display("FAIL expiry_pulse: enqueue=%h valid=%b required 0020/0", enqueue, running_valid);
      end
    end
    cyc();
    checks++;
    if (enqueue !== '0 || switch_req !== 1'b0) begin
      errors++;
      $display("FAIL expiry_settle: enqueue=%h req=%b required 0000/0", enqueue, switch_req);
    end
    cyc();
    checks++;
    if (switch_req !== 1'b1 || switch_tid !== 4'd9 || dequeue !== 16'h0200) begin
      errors++;
      $display("FAIL expiry_redispatch: req=%b tid=%0d dequeue=%h required 1/9/0200", switch_req, switch_tid, dequeue);
    end
    empty_flag = 1'b1;
    switch_ack = 1'b1;
    cyc();
    switch_ack = 1'b0;
    checks++;
    if (running_valid !== 1'b1 || running_tid !== 4'd9) begin
      errors++;
      $display("FAIL expiry_run9: valid=%b running_tid=%0d required 1/9", running_valid, running_tid);
    end
  endtask

  task automatic test_expiry_empty();
    for (int c = 1; c <= 24; c++) begin
      cyc();
      checks++;
      if (c < 24 && (enqueue !== '0 || running_valid !== 1'b1 || running_tid !== 4'd9)) begin
        errors++;
        $display("FAIL empty_keep cycle %0d: enqueue=%h valid=%b tid=%0d required 0000/1/9", c, enqueue, running_valid, running_tid);
      end else if (c == 24 && (enqueue !== 16'h0200 || running_valid !== 1'b0)) begin
        errors++;
        $display("FAIL empty_late_pulse: enqueue=%h valid=%b required 0200/0", enqueue, running_valid);
      end
      if (c == 16) begin
        qhead_tid = 4'd2;
        empty_flag = 1'b0;
      end
    end
    empty_flag = 1'b1;
    cyc();
  endtask

  task automatic test_priority();
    dispatch(4'd3);
    cpu_exit = 1'b1;
    cpu_block = 1'b1;
    cpu_yield = 1'b1;
    cyc();
    cpu_exit = 1'b0;
    cpu_block = 1'b0;
    cpu_yield = 1'b0;
    checks++;
    if (remove !== 16'h0008 || que_blk !== '0 || enqueue !== '0 || running_valid !== 1'b0) begin
      errors++;
      $display("FAIL prio_exit: remove=%h que_blk=%h enqueue=%h valid=%b required 0008/0/0/0", remove, que_blk, enqueue, running_valid);
    end
    cyc();
    checks++;
    if (remove !== '0) begin
      errors++;
      $display("FAIL prio_one_cycle: remove=%h required 0000", remove);
    end
    dispatch(4'd6);
    cpu_block = 1'b1;
    cpu_yield = 1'b1;
    cyc();
    cpu_block = 1'b0;
    cpu_yield = 1'b0;
    checks++;
    if (que_blk !== 16'h0040 || enqueue !== '0 || remove !== '0) begin
      errors++;
      $display("FAIL prio_block: que_blk=%h enqueue=%h remove=%h required 0040/0/0", que_blk, enqueue, remove);
    end
    cyc();
  endtask

  task automatic test_yield_self();
    dispatch(4'd12);
    repeat (2) cyc();
    cpu_yield = 1'b1;
    cyc();
    cpu_yield = 1'b0;
    checks++;
    if (enqueue !== 16'h1000 || running_valid !== 1'b0) begin
      errors++;
      $display("FAIL yield_pulse: enqueue=%h valid=%b required 1000/0", enqueue, running_valid);
    end
    qhead_tid = 4'd12;
    empty_flag = 1'b0;
    repeat (2) cyc();
    checks++;
    if (switch_req !== 1'b1 || switch_tid !== 4'd12 || dequeue !== 16'h1000) begin
      errors++;
      $display("FAIL yield_redispatch: req=%b tid=%0d dequeue=%h required 1/12/1000", switch_req, switch_tid, dequeue);
    end
    empty_flag = 1'b1;
    switch_ack = 1'b1;
    cyc();
    switch_ack = 1'b0;
  endtask

  task automatic test_rst_launch();
    cpu_exit = 1'b1;
    cyc();
    cpu_exit = 1'b0;
    qhead_tid = 4'd4;
    empty_flag = 1'b0;
    repeat (2) cyc();
    checks++;
    if (switch_req !== 1'b1 || switch_tid !== 4'd4) begin
      errors++;
      $display("FAIL rst_pre_launch: req=%b tid=%0d required 1/4", switch_req, switch_tid);
    end
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    checks++;
    if ({dequeue, enqueue, que_blk, remove, switch_req, switch_tid, running_valid, running_tid} !== '0) begin
      errors++;
      $display("FAIL rst_in_launch: outputs=%h required 0",
               {dequeue, enqueue, que_blk, remove, switch_req, switch_tid, running_valid, running_tid});
    end
    empty_flag = 1'b1;
    switch_ack = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      checks++;
      if (running_valid !== 1'b0 || switch_req !== 1'b0) begin
        errors++;
        $display("FAIL rst_ack_ignored cycle %0d: valid=%b req=%b required 0/0", i, running_valid, switch_req);
      end
    end
    switch_ack = 1'b0;
    qhead_tid = 4'd7;
    empty_flag = 1'b0;
    cyc();
    checks++;
    if (switch_req !== 1'b1 || switch_tid !== 4'd7 || dequeue !== 16'h0080) begin
      errors++;
      $display("FAIL rst_redispatch: req=%b tid=%0d dequeue=%h required 1/7/0080", switch_req, switch_tid, dequeue);
    end
    empty_flag = 1'b1;
    switch_ack = 1'b1;
    cyc();
    switch_ack = 1'b0;
    checks++;
    if (running_valid !== 1'b1 || running_tid !== 4'd7) begin
      errors++;
      $display("FAIL rst_run7: valid=%b running_tid=%0d required 1/7", running_valid, running_tid);
    end
  endtask

  initial begin
    test_reset();
    test_dispatch();
    test_expiry();
    test_expiry_empty();
    test_priority();
    test_yield_self();
    test_rst_launch();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
